// File: rtl/ex_stg.sv
// rtl/ex_stg.sv - execute stage: ID/EX and EX/MEM registers, operand forwarding, ALU, load-use stall
// A bubble clears control and register fields only; the data fields keep loading the decode inputs.

module ex_stg #(
    parameter int DW = 32,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [DW-1:0] id_imm,
    input  logic [2:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regWrite,
    input  logic          id_memRead,
    input  logic          id_memWrite,
    input  logic          flush,
    input  logic [1:0]    forwardA,
    input  logic [1:0]    forwardB,
    input  logic [DW-1:0] mem_wb_data,
    output logic [RW-1:0] id_ex_rs,
    output logic [RW-1:0] id_ex_rt,
    output logic          stall,
    output logic          ex_mem_regWrite,
    output logic          ex_mem_memRead,
    output logic          ex_mem_memWrite,
    output logic [RW-1:0] ex_mem_rd,
    output logic [DW-1:0] ex_mem_alu,
    output logic [DW-1:0] ex_mem_wdata,
    output logic          ex_mem_zero
);

    logic [RW-1:0] id_ex_rs_q, id_ex_rs_d, id_ex_rt_q, id_ex_rt_d, id_ex_rd_q, id_ex_rd_d;
    logic [DW-1:0] id_ex_a_q, id_ex_a_d, id_ex_b_q, id_ex_b_d, id_ex_imm_q, id_ex_imm_d;
    logic [2:0]    id_ex_aluop_q, id_ex_aluop_d;
    logic          id_ex_alusrc_q, id_ex_alusrc_d;
    logic          id_ex_regWrite_q, id_ex_regWrite_d;
    logic          id_ex_memRead_q, id_ex_memRead_d;
    logic          id_ex_memWrite_q, id_ex_memWrite_d;

    logic          ex_mem_regWrite_q, ex_mem_regWrite_d;
    logic          ex_mem_memRead_q, ex_mem_memRead_d;
    logic          ex_mem_memWrite_q, ex_mem_memWrite_d;
    logic [RW-1:0] ex_mem_rd_q, ex_mem_rd_d;
    logic [DW-1:0] ex_mem_alu_q, ex_mem_alu_d;
    logic [DW-1:0] ex_mem_wdata_q, ex_mem_wdata_d;
    logic          ex_mem_zero_q, ex_mem_zero_d;

    logic [DW-1:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [4:0]    shamt;

    // For a load the rt field names the destination register.
    assign stall = id_ex_memRead_q && ((id_ex_rt_q == id_rs) || (id_ex_rt_q == id_rt));

    always_comb begin
        id_ex_rs_d       = id_rs;
        id_ex_rt_d       = id_rt;
        id_ex_rd_d       = id_rd;
        id_ex_a_d        = id_a;
        id_ex_b_d        = id_b;
        id_ex_imm_d      = id_imm;
        id_ex_aluop_d    = id_aluop;
        id_ex_alusrc_d   = id_alusrc;
        id_ex_regWrite_d = id_regWrite;
        id_ex_memRead_d  = id_memRead;
        id_ex_memWrite_d = id_memWrite;
        if (flush || stall) begin
            id_ex_rs_d       = '0;
            id_ex_rt_d       = '0;
            id_ex_rd_d       = '0;
            id_ex_aluop_d    = '0;
            id_ex_alusrc_d   = 1'b0;
            id_ex_regWrite_d = 1'b0;
            id_ex_memRead_d  = 1'b0;
            id_ex_memWrite_d = 1'b0;
        end
    end

    always_comb begin
        fwd_a = id_ex_a_q;
        fwd_b = id_ex_b_q;
        case (forwardA)
            2'b10:   fwd_a = ex_mem_alu_q;
            2'b01:   fwd_a = mem_wb_data;
            default: fwd_a = id_ex_a_q;
        endcase
        case (forwardB)
            2'b10:   fwd_b = ex_mem_alu_q;
            2'b01:   fwd_b = mem_wb_data;
            default: fwd_b = id_ex_b_q;
        endcase
        alu_b = id_ex_alusrc_q ? id_ex_imm_q : fwd_b;
        shamt = alu_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (id_ex_aluop_q)
            3'b000:  alu_res = fwd_a + alu_b;
            3'b001:  alu_res = fwd_a - alu_b;
            3'b010:  alu_res = fwd_a & alu_b;
            3'b011:  alu_res = fwd_a | alu_b;
            3'b100:  alu_res = fwd_a ^ alu_b;
            3'b101:  alu_res = fwd_a << shamt;
            3'b110:  alu_res = fwd_a >> shamt;
            default: alu_res[0] = ($signed(fwd_a) < $signed(alu_b));
        endcase
    end

    always_comb begin
        ex_mem_regWrite_d = id_ex_regWrite_q;
        ex_mem_memRead_d  = id_ex_memRead_q;
        ex_mem_memWrite_d = id_ex_memWrite_q;
        ex_mem_rd_d       = id_ex_rd_q;
        ex_mem_alu_d      = alu_res;
        ex_mem_wdata_d    = fwd_b;
        ex_mem_zero_d     = (alu_res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_rs_q        <= '0;
            id_ex_rt_q        <= '0;
            id_ex_rd_q        <= '0;
            id_ex_a_q         <= '0;
            id_ex_b_q         <= '0;
            id_ex_imm_q       <= '0;
            id_ex_aluop_q     <= '0;
            id_ex_alusrc_q    <= 1'b0;
            id_ex_regWrite_q  <= 1'b0;
            id_ex_memRead_q   <= 1'b0;
            id_ex_memWrite_q  <= 1'b0;
            ex_mem_regWrite_q <= 1'b0;
            ex_mem_memRead_q  <= 1'b0;
            ex_mem_memWrite_q <= 1'b0;
            ex_mem_rd_q       <= '0;
            ex_mem_alu_q      <= '0;
            ex_mem_wdata_q    <= '0;
            ex_mem_zero_q     <= 1'b0;
        end else begin
            id_ex_rs_q        <= id_ex_rs_d;
            id_ex_rt_q        <= id_ex_rt_d;
            id_ex_rd_q        <= id_ex_rd_d;
            id_ex_a_q         <= id_ex_a_d;
            id_ex_b_q         <= id_ex_b_d;
            id_ex_imm_q       <= id_ex_imm_d;
            id_ex_aluop_q     <= id_ex_aluop_d;
            id_ex_alusrc_q    <= id_ex_alusrc_d;
            id_ex_regWrite_q  <= id_ex_regWrite_d;
            id_ex_memRead_q   <= id_ex_memRead_d;
            id_ex_memWrite_q  <= id_ex_memWrite_d;
            ex_mem_regWrite_q <= ex_mem_regWrite_d;
            ex_mem_memRead_q  <= ex_mem_memRead_d;
            ex_mem_memWrite_q <= ex_mem_memWrite_d;
            ex_mem_rd_q       <= ex_mem_rd_d;
            ex_mem_alu_q      <= ex_mem_alu_d;
            ex_mem_wdata_q    <= ex_mem_wdata_d;
            ex_mem_zero_q     <= ex_mem_zero_d;
        end
    end

    assign id_ex_rs        = id_ex_rs_q;
    assign id_ex_rt        = id_ex_rt_q;
    assign ex_mem_regWrite = ex_mem_regWrite_q;
    assign ex_mem_memRead  = ex_mem_memRead_q;
    assign ex_mem_memWrite = ex_mem_memWrite_q;
    assign ex_mem_rd       = ex_mem_rd_q;
    assign ex_mem_alu      = ex_mem_alu_q;
    assign ex_mem_wdata    = ex_mem_wdata_q;
    assign ex_mem_zero     = ex_mem_zero_q;

endmodule

// File: tb/tb_ex_stg.sv
// tb/tb_ex_stg.sv - scoreboard bench for ex_stg: directed instructions, expected EX/MEM contents queued at issue
// A monitor pops each expectation on the edge count at which the instruction reaches EX/MEM.

module tb_ex_stg;

    logic        clk, rst_n;
    logic [2:0]  id_rs, id_rt, id_rd, id_aluop;
    logic [31:0] id_a, id_b, id_imm, mem_wb_data;
    logic        id_alusrc, id_regWrite, id_memRead, id_memWrite, flush;
    logic [1:0]  forwardA, forwardB;
    logic [2:0]  id_ex_rs, id_ex_rt, ex_mem_rd;
    logic        stall, ex_mem_regWrite, ex_mem_memRead, ex_mem_memWrite, ex_mem_zero;
    logic [31:0] ex_mem_alu, ex_mem_wdata;

    typedef struct {
        int          due;
        bit          chk;
        logic        rw, mr, mw;
        logic [2:0]  rd;
        logic [31:0] alu, wdata;
        logic        zero;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;

    ex_stg #(.DW(32), .RW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .flush(flush), .forwardA(forwardA), .forwardB(forwardB), .mem_wb_data(mem_wb_data),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .stall(stall),
        .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_memRead(ex_mem_memRead),
        .ex_mem_memWrite(ex_mem_memWrite), .ex_mem_rd(ex_mem_rd),
        .ex_mem_alu(ex_mem_alu), .ex_mem_wdata(ex_mem_wdata), .ex_mem_zero(ex_mem_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= edge_n) begin
            rec_t r;
            r = sb.pop_front();
            chk("late_record", edge_n, r.due);
            chk("regWrite", ex_mem_regWrite, r.rw);
            chk("memRead", ex_mem_memRead, r.mr);
            chk("memWrite", ex_mem_memWrite, r.mw);
            chk("rd", ex_mem_rd, r.rd);
            if (r.chk) begin
                chk("alu", ex_mem_alu, r.alu);
                chk("wdata", ex_mem_wdata, r.wdata);
                chk("zero", ex_mem_zero, r.zero);
            end
        end
    end

    task automatic dec(input logic [2:0] rs, rt, rd, input logic [31:0] a, b, imm,
                       input logic [2:0] op, input logic src, rw, mr, mw);
        id_rs = rs; id_rt = rt; id_rd = rd; id_a = a; id_b = b; id_imm = imm;
        id_aluop = op; id_alusrc = src; id_regWrite = rw; id_memRead = mr; id_memWrite = mw;
    endtask

    task automatic nop();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fwd(input logic [1:0] fa, fb, input logic [31:0] wb);
        forwardA = fa; forwardB = fb; mem_wb_data = wb;
    endtask

    // Called at a falling edge with decode inputs already driven; bub marks a bubble entering ID/EX.
    task automatic tick(input bit exp_stall, input bit bub, input logic [2:0] rd,
                        input logic rw, mr, mw, input logic [31:0] alu, wdata, input logic zero);
        rec_t r;
        #1;
        chk("stall", stall, exp_stall);
        r.due = edge_n + 2; r.chk = !bub; r.rw = rw; r.mr = mr; r.mw = mw;
        r.rd = rd; r.alu = alu; r.wdata = wdata; r.zero = zero;
        sb.push_back(r);
        @(negedge clk);
        fwd(2'b00, 2'b00, 32'h0);
        flush = 1'b0;
    endtask

    task automatic tick_nop();
        nop();
        tick(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    endtask

    task automatic tick_bubble();
        tick(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom);
            fwd($urandom, $urandom, $urandom);
            flush = $urandom;
            @(negedge clk);
        end
        chk("rst_id_ex_rs", id_ex_rs, 0);
        chk("rst_id_ex_rt", id_ex_rt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_regWrite", ex_mem_regWrite, 0);
        chk("rst_memRead", ex_mem_memRead, 0);
        chk("rst_memWrite", ex_mem_memWrite, 0);
        chk("rst_rd", ex_mem_rd, 0);
        chk("rst_alu", ex_mem_alu, 0);
        chk("rst_wdata", ex_mem_wdata, 0);
        chk("rst_zero", ex_mem_zero, 0);
        nop(); fwd(0, 0, 0); flush = 1'b0; rst_n = 1'b1;

        // first instruction after reset: ADD 5 + 7
        dec(1, 2, 1, 5, 7, 0, 3'b000, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 32'd12, 32'd7, 0);

        // EX/MEM forward: ADD r1 = 3 + 4, SUB r2 = r1 - 2 with stale a=99
        dec(2, 3, 1, 3, 4, 0, 3'b000, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 32'd7, 32'd4, 0);
        dec(1, 4, 2, 99, 2, 0, 3'b001, 0, 1, 0, 0);
        tick(0, 0, 2, 1, 0, 0, 32'd5, 32'd2, 0);
        nop(); fwd(2'b10, 2'b00, 32'h0);
        tick(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

        // MEM/WB forward on B, then code 11 falls back to the register value
        dec(1, 2, 5, 32'hFF, 32'h77, 0, 3'b010, 0, 1, 0, 0);
        tick(0, 0, 5, 1, 0, 0, 32'h10, 32'h10, 0);
        dec(1, 2, 6, 32'hFF, 32'h0F, 0, 3'b010, 0, 1, 0, 0);
        fwd(2'b00, 2'b01, 32'h10);
        tick(0, 0, 6, 1, 0, 0, 32'h0F, 32'h0F, 0);
        nop(); fwd(2'b00, 2'b11, 32'h10);
        tick(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

        // load-use: LW r3 = [0x100+8], then ADD r4 = r3 + r1 stalls once and takes load data via 01
        dec(1, 3, 3, 32'h100, 0, 8, 3'b000, 1, 1, 1, 0);
        tick(0, 0, 3, 1, 1, 0, 32'h108, 32'h0, 0);
        dec(3, 1, 4, 77, 10, 0, 3'b000, 0, 1, 0, 0);
        tick_bubble();
        dec(3, 1, 4, 77, 10, 0, 3'b000, 0, 1, 0, 0);
        tick(0, 0, 4, 1, 0, 0, 32'h2A, 32'd10, 0);
        nop(); fwd(2'b01, 2'b00, 32'h20);
        tick(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

        // flush together with a load-use hazard: one bubble, no write or memory access
        dec(0, 5, 5, 32'h40, 32'h0, 0, 3'b000, 1, 1, 1, 0);
        tick(0, 0, 5, 1, 1, 0, 32'h40, 32'h0, 0);
        dec(5, 0, 7, 1, 1, 0, 3'b000, 0, 1, 0, 1);
        flush = 1'b1;
        tick_bubble();
        tick_nop();

        // back-to-back loads: LW r6, LW r7 using r6, ADD using r7
        dec(0, 6, 6, 32'h200, 32'h0, 0, 3'b000, 1, 1, 1, 0);
        tick(0, 0, 6, 1, 1, 0, 32'h200, 32'h0, 0);
        dec(6, 7, 7, 32'h300, 32'h0, 4, 3'b000, 1, 1, 1, 0);
        tick_bubble();
        dec(6, 7, 7, 32'h300, 32'h0, 4, 3'b000, 1, 1, 1, 0);
        tick(0, 0, 7, 1, 1, 0, 32'h304, 32'h0, 0);
        dec(7, 0, 1, 1, 2, 0, 3'b000, 0, 1, 0, 0);
        tick_bubble();
        dec(7, 0, 1, 1, 2, 0, 3'b000, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 32'd3, 32'd2, 0);

        // ALU corners
        dec(1, 2, 3, 32'h8000_0000, 32'd1, 0, 3'b111, 0, 1, 0, 0);
        tick(0, 0, 3, 1, 0, 0, 32'd1, 32'd1, 0);
        dec(1, 2, 3, 32'h8000_0000, 32'd31, 0, 3'b110, 0, 1, 0, 0);
        tick(0, 0, 3, 1, 0, 0, 32'd1, 32'd31, 0);
        dec(1, 2, 3, 32'd3, 32'd33, 0, 3'b101, 0, 1, 0, 0);
        tick(0, 0, 3, 1, 0, 0, 32'd6, 32'd33, 0);
        dec(1, 2, 3, 32'hFFFF_FFFF, 32'd1, 0, 3'b000, 0, 1, 0, 0);
        tick(0, 0, 3, 1, 0, 0, 32'd0, 32'd1, 1);
        dec(1, 2, 4, 32'd4, 32'h55, 32'hFFFF_FFFC, 3'b000, 1, 1, 0, 0);
        tick(0, 0, 4, 1, 0, 0, 32'd0, 32'h55, 1);
        dec(1, 2, 5, 32'hF0F0, 32'h0FF0, 0, 3'b100, 0, 0, 0, 1);
        tick(0, 0, 5, 0, 0, 1, 32'hFF00, 32'h0FF0, 0);
        dec(1, 2, 5, 32'hF000, 32'h000F, 0, 3'b011, 0, 1, 0, 0);
        tick(0, 0, 5, 1, 0, 0, 32'hF00F, 32'h000F, 0);
        nop();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stg.md
# ex_stg

Execute-stage block of the 32-bit pipelined RISC core. It holds the ID/EX pipeline register and the EX/MEM pipeline register. It selects ALU operands from the register file, the EX/MEM result or the MEM/WB write-back data, as directed by the forwarding unit's `forwardA`/`forwardB` codes. It also detects load-use hazards and inserts one bubble per hazard, raising a stall to the fetch/decode stages.

## Interface

**Parameters**
- `DW`, 32: datapath width.
- `RW`, 3: register address width (8 registers).

**Ports**
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_rs`, `id_rt`, `id_rd` in RW: register fields of the instruction in decode.
- `id_a`, `id_b` in DW: register-file read data for rs and rt.
- `id_imm` in DW: sign-extended immediate.
- `id_aluop` in 3: ALU operation.
- `id_alusrc` in 1: 1 = operand B is the immediate.
- `id_regWrite`, `id_memRead`, `id_memWrite` in 1: decode control.
- `flush` in 1: branch taken; squash the instruction in decode.
- `forwardA`, `forwardB` in 2: forwarding select from the forwarding unit.
- `mem_wb_data` in DW: write-back data.
- `id_ex_rs`, `id_ex_rt` out RW: registered source fields, to the forwarding unit.
- `stall` out 1: load-use hazard; freeze the PC and IF/ID.
- `ex_mem_regWrite`, `ex_mem_memRead`, `ex_mem_memWrite` out 1: registered control.
- `ex_mem_rd` out RW: destination register.
- `ex_mem_alu` out DW: ALU result.
- `ex_mem_wdata` out DW: forwarded rt value, used as store data.
- `ex_mem_zero` out 1: ALU result equals 0.

## Operation

**Forwarding mux (per operand)**
- Code 00: register value (`id_ex_a` / `id_ex_b`).
- Code 10: `ex_mem_alu`.
- Code 01: `mem_wb_data`.
- Code 11: treated as 00.
- `ex_mem_wdata` always takes the forwarded B value before the immediate mux.
- ALU B input = `id_alusrc` registered ? `id_ex_imm` : forwarded B.

**ALU ops** (all results DW wide, wrap on overflow, no flags except zero)
- 000 ADD.
- 001 SUB.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 SLL: A << B[4:0].
- 110 SRL: logical, A >> B[4:0].
- 111 SLT: signed, result 32'd1 or 32'd0.

**Hazard detection**
- `stall` is combinational from the ID/EX register and decode inputs: `stall = id_ex_memRead && (id_ex_rt == id_rs || id_ex_rt == id_rt)`.
- The comparison uses the registered rt field; for loads the rt field is the load destination.

**ID/EX load, each clock edge**
- If `flush || stall`: load a bubble. All control bits are 0, all register fields are 0, and the data fields hold don't-care values; the bench must not check them.
- Otherwise: load the decode inputs.
- `flush` and `stall` both high: bubble, same as either alone.

**EX/MEM load, each clock edge**
- Always loads the EX result. It has no enable.
- A bubble propagates as regWrite=0, memRead=0, memWrite=0, rd=0.

## Timing

- **Reset:** while `rst_n` is low, every registered output and every internal register is 0: `id_ex_rs`, `id_ex_rt`, all `ex_mem_*` outputs, and `ex_mem_zero`. `stall` is therefore 0 during reset.
- **Reset mid-operation:** in-flight instructions are lost. The first edge after release loads decode normally.
- **Latency:** an instruction presented in decode at edge N is in ID/EX after edge N. Its result appears on `ex_mem_*` after edge N+1.
- **Forwarding path:** `forwardA`/`forwardB` arrive combinationally in the same cycle as `id_ex_rs`/`id_ex_rt` are valid. The mux and ALU settle within that cycle.
- **Load-use stall:** asserted for exactly one cycle per dependent load. On the following edge the bubble enters ID/EX, `id_ex_memRead` drops, and `stall` clears. The held decode instruction then enters on the next edge and receives the load data via code 01.
- **Back-to-back loads:** a second load that depends on the first stalls once. A non-load dependent on it then stalls once more.

## Test plan

1. **Reset:** hold `rst_n`=0 with random inputs, then release. All outputs read 0. The first instruction, ADD a=5 b=7, gives `ex_mem_alu`=12 two edges later.
2. **EX/MEM forward:** issue ADD r1 = 3 + 4, then SUB r2 = r1 − 2 with `forwardA`=10 and a stale `id_a`=99. Result: `ex_mem_alu`=5, `ex_mem_zero`=0.
3. **MEM/WB forward and code 11:** `forwardB`=01 with `mem_wb_data`=0x10 and AND a=0xFF gives 0x10. Repeat with `forwardB`=11 and `id_b`=0x0F: result 0x0F.
4. **Load-use:** load to r3, then ADD r4 = r3 + r1 in decode. `stall`=1 for exactly one cycle. The bubble reaches EX/MEM with regWrite=0 and rd=0. The ADD then completes with `forwardA`=01.
5. **Flush with stall:** assert `flush` and a load-use condition in the same cycle. A single bubble is loaded, and no write or memory access appears on `ex_mem_*`.
6. **ALU corners:**
   - SLT 0x80000000 vs 1 gives 1.
   - SRL 0x80000000 by 31 gives 1.
   - SLL by B=33 shifts by 1.
   - ADD 0xFFFFFFFF + 1 gives 0 with `ex_mem_zero`=1.
   - `id_alusrc`=1 with `id_imm`=−4 and a=4 gives 0, while `ex_mem_wdata` still equals the forwarded rt value.
